gen3_tx_gearbox: RTL and testbench

- Gen3 transmit gearbox, directly downstream of scrambler_top in the TX lane datapath.
- Takes 32-bit scrambled words plus a 2-bit sync header per 128-bit block.
- Packs the resulting 130-bit blocks into a continuous 32-bit output stream for the serializer.
- Back-pressures upstream with ready_o: one stall cycle every 16 blocks (64 words in, 65 words out).

---
 rtl/pcie_gen3_pkg.sv | 17 +
 rtl/gen3_blk_checker.sv | 53 +++++
 rtl/gen3_tx_gearbox.sv | 114 +++++++++++
 tb/tb_gen3_tx_gearbox.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_gen3_pkg.sv
// Shared Gen3 PCIe lane definitions.
// Holds the sync header encodings, the 128b/130b block geometry and a small
// helper that tells whether a sync header is one of the two legal codes.
package pcie_gen3_pkg;

  typedef logic [1:0] sync_hdr_t;

  localparam sync_hdr_t SYNC_HDR_DATA      = 2'b01;
  localparam sync_hdr_t SYNC_HDR_OS        = 2'b10;
  localparam int        GEN3_BLK_BITS      = 130;
  localparam int        GEN3_WORDS_PER_BLK = 4;

  function automatic logic sync_hdr_legal(input sync_hdr_t hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_OS);
  endfunction

endpackage

// File: rtl/gen3_blk_checker.sv
// Gen3 block framing checker for the TX gearbox.
// Tracks the word index inside the current 128-bit block and raises a sticky
// error when a block_start arrives mid-block, a block is continued without a
// preceding block_start, or a block_start carries an illegal sync header.
// Ports:
//   clk_i, rst_i   lane clock, asynchronous active-low reset
//   clr_i          synchronous flush; clears the word index, not the error
//   accept         a word is consumed by the gearbox this cycle (flush-qualified)
//   block_start    the consumed word is word 0 of a block
//   sync_hdr       header sampled with block_start
//   proto_err      sticky error flag, cleared only by reset
module gen3_blk_checker
  import pcie_gen3_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clr_i,
  input  logic      accept,
  input  logic      block_start,
  input  sync_hdr_t sync_hdr,
  output logic      proto_err
);

  logic [1:0] wrd_q;
  logic       bad_word;

  always_comb begin
    bad_word = 1'b0;
    if (block_start) begin
      bad_word = (wrd_q != 2'd0) || !sync_hdr_legal(sync_hdr);
    end else begin
      bad_word = (wrd_q == 2'd0);
    end
  end

  // Index wraps naturally at 4 words; a block_start always re-synchronises it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wrd_q     <= 2'd0;
      proto_err <= 1'b0;
    end else begin
      if (clr_i) begin
        wrd_q <= 2'd0;
      end else if (accept) begin
        wrd_q <= block_start ? 2'd1 : wrd_q + 2'd1;
      end
      if (accept && bad_word) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen3_tx_gearbox.sv
// Gen3 transmit gearbox (128b/130b), downstream of the scrambler.
// Packs {data, sync header} blocks into a continuous 32-bit stream. Every
// 16 blocks the 2-bit headers add up to one extra output word, so ready
// drops for one cycle while that residue drains.
// Optional build macro: GEARBOX_PROTO_CHK_EN enables the block framing
// checker driving proto_err_o; otherwise proto_err_o is tied low.
// Ports:
//   clk_i          lane clock
//   rst_i          asynchronous active-low reset
//   clr_i          synchronous flush of residue (rate change / idle entry)
//   data_i         scrambled data word, bit 0 transmitted first
//   data_valid_i   data_i valid
//   block_start_i  data_i is word 0 of a block; header goes in front of it
//   sync_hdr_i     sync header, bit 0 sent first, sampled with block_start_i
//   ready_o        word accepted this cycle when data_valid_i is high
//   data_o         packed output word, bit 0 sent first
//   data_valid_o   data_o valid
//   proto_err_o    sticky framing error (checker builds only)
module gen3_tx_gearbox
  import pcie_gen3_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int HDR_W         = 2,
  parameter int WORDS_PER_BLK = GEN3_WORDS_PER_BLK
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  input  logic              block_start_i,
  input  logic [HDR_W-1:0]  sync_hdr_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              proto_err_o
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int IN_W   = DATA_W + HDR_W;
  localparam int FILL_W = 7;

  // Only the 32-bit, 4-words-per-block geometry is implemented.
  if (DATA_W * WORDS_PER_BLK + HDR_W != GEN3_BLK_BITS) begin : g_cfg_check
    $error("gen3_tx_gearbox: unsupported DATA_W/WORDS_PER_BLK/HDR_W combination");
  end

  logic [BUF_W-1:0]  buf_q;
  logic [FILL_W-1:0] fill_q;
  logic              accept;
  logic [IN_W-1:0]   in_bits;
  logic [FILL_W-1:0] add_bits;
  logic [FILL_W-1:0] new_fill;
  logic [BUF_W-1:0]  merged;

  // Bits at or above fill_q in buf_q are always zero, so new bits can be
  // OR-ed in at the fill position.
  assign ready_o = (fill_q < FILL_W'(DATA_W));
  assign accept  = data_valid_i & ready_o;

  always_comb begin
    in_bits  = '0;
    add_bits = '0;
    if (accept) begin
      if (block_start_i) begin
        in_bits  = {data_i, sync_hdr_i};
        add_bits = FILL_W'(IN_W);
      end else begin
        in_bits  = {{HDR_W{1'b0}}, data_i};
        add_bits = FILL_W'(DATA_W);
      end
    end
    merged   = buf_q | (BUF_W'(in_bits) << fill_q);
    new_fill = fill_q + add_bits;
  end

  // Flush clears the buffer too, keeping the zero-above-fill invariant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q        <= '0;
      fill_q       <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else if (clr_i) begin
      buf_q        <= '0;
      fill_q       <= '0;
      data_valid_o <= 1'b0;
    end else if (new_fill >= FILL_W'(DATA_W)) begin
      data_o       <= merged[DATA_W-1:0];
      data_valid_o <= 1'b1;
      buf_q        <= merged >> DATA_W;
      fill_q       <= new_fill - FILL_W'(DATA_W);
    end else begin
      data_valid_o <= 1'b0;
      buf_q        <= merged;
      fill_q       <= new_fill;
    end
  end

`ifdef GEARBOX_PROTO_CHK_EN
  gen3_blk_checker u_blk_checker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .accept      (accept & ~clr_i),
    .block_start (block_start_i),
    .sync_hdr    (sync_hdr_i),
    .proto_err   (proto_err_o)
  );
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gen3_tx_gearbox.sv
// Self-checking bench for gen3_tx_gearbox.
// A serial bit queue holds every accepted bit in transmit order; each output
// word is checked against the next 32 bits, alongside hand-computed vectors.
module tb_gen3_tx_gearbox;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        block_start_i;
  logic [1:0]  sync_hdr_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        proto_err_o;

  int          nTests = 0;
  int          nFail  = 0;
  bit          expQ[$];
  logic [31:0] outWords[$];
  logic [31:0] refWords[$];
  logic [31:0] blkData[64];
  logic        lastAccepted;
  logic        expErr;

  always #5 clk_i = ~clk_i;

  gen3_tx_gearbox dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (clr_i),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .block_start_i (block_start_i),
    .sync_hdr_i    (sync_hdr_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .proto_err_o   (proto_err_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called #1 after a rising edge: drives one cycle, updates the bit queue
  // and checks the registered outputs after the next edge.
  task automatic applyStimulus(input logic v, input logic bs, input logic [1:0] hdr,
                               input logic [31:0] d, input logic clr);
    logic [31:0] expWord;
    checkOutput("ready", ready_o, 64'(expQ.size() < 32));
    lastAccepted  = v & ready_o & ~clr;
    data_valid_i  = v;
    block_start_i = bs;
    sync_hdr_i    = hdr;
    data_i        = d;
    clr_i         = clr;
    if (clr) begin
      expQ.delete();
    end else if (lastAccepted) begin
      if (bs) begin
        expQ.push_back(hdr[0]);
        expQ.push_back(hdr[1]);
      end
      for (int i = 0; i < 32; i++) expQ.push_back(d[i]);
    end
    @(posedge clk_i);
    #1;
    if (expQ.size() >= 32) begin
      for (int i = 0; i < 32; i++) expWord[i] = expQ.pop_front();
      checkOutput("dv_hi", data_valid_o, 1);
      checkOutput("data", data_o, expWord);
    end else begin
      checkOutput("dv_lo", data_valid_o, 0);
    end
    if (data_valid_o) outWords.push_back(data_o);
    data_valid_i = 1'b0;
    clr_i        = 1'b0;
  endtask

  task automatic doReset();
    rst_i = 1'b0;
    #1;
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_dv", data_valid_o, 0);
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_err", proto_err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    expQ.delete();
    outWords.delete();
  endtask

  // 16 back-to-back blocks, optionally with a 3-cycle upstream gap mid-block.
  task automatic runBlocks(input bit withGap, output int stallCount, output int stallAt,
                           output int gapLow);
    int idx;
    int cycles;
    int gapLeft;
    idx        = 0;
    cycles     = 0;
    gapLeft    = withGap ? 3 : 0;
    stallCount = 0;
    stallAt    = -1;
    gapLow     = 0;
    while (idx < 64 && cycles < 300) begin
      if (idx == 6 && gapLeft > 0) begin
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
        if (!data_valid_o) gapLow++;
        gapLeft--;
      end else begin
        if (!ready_o) begin
          stallCount++;
          stallAt = idx;
        end
        applyStimulus(1'b1, (idx % 4) == 0, ((idx / 4) % 2) ? 2'b10 : 2'b01,
                      blkData[idx], 1'b0);
        if (lastAccepted) idx++;
      end
      cycles++;
    end
    checkOutput("blk_timeout", idx, 64);
    for (int i = 0; i < 3; i++) begin
      if (!ready_o) stallCount++;
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    end
  endtask

  initial begin
    int stallCount;
    int stallAt;
    int gapLow;
    rst_i         = 1'b0;
    clr_i         = 1'b0;
    data_i        = '0;
    data_valid_i  = 1'b0;
    block_start_i = 1'b0;
    sync_hdr_i    = 2'b00;
    for (int i = 0; i < 64; i++) blkData[i] = (32'h9E3779B9 * (i + 1)) ^ (32'h00FF00FF << (i % 8));
    @(posedge clk_i);
    #1;
    doReset();

    // Single block after reset
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h00000000, 1'b0);
    checkOutput("blk0_w0", data_o, 32'h00000001);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b0);
    checkOutput("blk0_w1", data_o, 32'hFFFFFFFC);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h00000000, 1'b0);
    checkOutput("blk0_w2", data_o, 32'h00000003);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 1'b0);
    checkOutput("blk0_w3", data_o, 32'hFFFFFFFC);
    checkOutput("blk0_residue", expQ.size(), 2);

    // 16 back-to-back blocks; the header of block 16 takes fill from 30 to 64,
    // so the single stall follows the 61st accepted word.
    doReset();
    runBlocks(1'b0, stallCount, stallAt, gapLow);
    checkOutput("b2b_stalls", stallCount, 1);
    checkOutput("b2b_stall_at", stallAt, 61);
    checkOutput("b2b_outputs", outWords.size(), 65);
    refWords = outWords;
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h00000000, 1'b0);
    checkOutput("b2b_fill_zero", data_o, 32'h00000001);

    // Upstream gap gives the same bitstream
    doReset();
    runBlocks(1'b1, stallCount, stallAt, gapLow);
    checkOutput("gap_dv_low", gapLow, 3);
    checkOutput("gap_stalls", stallCount, 1);
    checkOutput("gap_outputs", outWords.size(), 65);
    for (int i = 0; i < 65 && i < outWords.size() && i < refWords.size(); i++)
      checkOutput("gap_word", outWords[i], refWords[i]);

    // Flush at fill 6 with a word offered in the same cycle
    doReset();
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, (i % 4) == 0, 2'b01, blkData[i], 1'b0);
    checkOutput("clr_pre_fill", expQ.size(), 6);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 1'b1);
    checkOutput("clr_dv", data_valid_o, 0);
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h12345678, 1'b0);
    checkOutput("clr_hdr_os", data_o, 32'h48D159E2);

    // Asynchronous reset off the clock edge, then resume
    doReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, (i % 4) == 0, 2'b01, blkData[i], 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("arst_data", data_o, 0);
    checkOutput("arst_dv", data_valid_o, 0);
    checkOutput("arst_ready", ready_o, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    expQ.delete();
    applyStimulus(1'b1, 1'b1, 2'b10, 32'hA5A5A5A5, 1'b0);
    checkOutput("arst_resume", data_o, 32'h96969696);
    for (int i = 1; i < 8; i++)
      applyStimulus(1'b1, (i % 4) == 0, 2'b01, blkData[i], 1'b0);

    // Framing checker: block_start on the third word
`ifdef GEARBOX_PROTO_CHK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h11111111, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h22222222, 1'b0);
    checkOutput("proto_ok", proto_err_o, 0);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h33333333, 1'b0);
    checkOutput("proto_err", proto_err_o, 64'(expErr));
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
    checkOutput("proto_sticky", proto_err_o, 64'(expErr));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
